// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC, one/two-word instruction assembly, valid/ready issue, jump and halt
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       pulse; (re)starts fetching at START_ADDR from IDLE or HALT
//   imem_read, imem_addr        memory read strobe and word address (= pc)
//   imem_data                   combinational memory word for imem_addr
//   instr_valid, instr_ready    issue handshake towards the control unit
//   opcode, operand             issued words; operand is 0 for one-word instructions
//   has_operand, instr_pc       two-word flag, address of the opcode word
//   jump_en, jump_target        redirect, sampled only on the issue handshake
//   busy, halted, fault         status

module instruction_fetch_unit #(
    parameter int START_ADDR = 0,
    parameter int MEM_DEPTH  = 100,
    parameter int OPC_SETN   = 0,
    parameter int OPC_SETC   = 1,
    parameter int OPC_JNPZ   = 21,
    parameter int OPC_END    = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_read,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] opcode,
    output logic [15:0] operand,
    output logic        has_operand,
    output logic [15:0] instr_pc,
    input  logic        jump_en,
    input  logic [15:0] jump_target,
    output logic        busy,
    output logic        halted,
    output logic        fault
);

    localparam logic [15:0] START_W = 16'(START_ADDR);
    localparam logic [15:0] DEPTH_W = 16'(MEM_DEPTH);
    localparam logic [15:0] SETN_W  = 16'(OPC_SETN);
    localparam logic [15:0] SETC_W  = 16'(OPC_SETC);
    localparam logic [15:0] JNPZ_W  = 16'(OPC_JNPZ);
    localparam logic [15:0] END_W   = 16'(OPC_END);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_ARG,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] opcode_nxt, operand_nxt, instr_pc_nxt;
    logic        has_operand_nxt, halted_nxt, fault_nxt;

    logic pc_ok;
    logic jump_ok;
    logic two_word;
    logic handshake;

    // Range checks happen before the read strobe is raised, so an
    // out-of-range address is never presented as a read.
    assign pc_ok     = (pc < DEPTH_W);
    assign jump_ok   = (jump_target < DEPTH_W);
    assign two_word  = (imem_data == SETN_W) || (imem_data == SETC_W) || (imem_data == JNPZ_W);
    assign handshake = (state == S_ISSUE) && instr_ready;

    assign imem_addr   = pc;
    assign imem_read   = ((state == S_FETCH_OP) || (state == S_FETCH_ARG)) && pc_ok;
    assign instr_valid = (state == S_ISSUE);
    assign busy        = (state == S_FETCH_OP) || (state == S_FETCH_ARG) || (state == S_ISSUE);

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        opcode_nxt      = opcode;
        operand_nxt     = operand;
        has_operand_nxt = has_operand;
        instr_pc_nxt    = instr_pc;
        halted_nxt      = halted;
        fault_nxt       = fault;

        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_nxt    = START_W;
                    state_nxt = S_FETCH_OP;
                end
            end

            S_FETCH_OP: begin
                if (!pc_ok) begin
                    fault_nxt  = 1'b1;
                    halted_nxt = 1'b1;
                    state_nxt  = S_HALT;
                end else begin
                    opcode_nxt   = imem_data;
                    instr_pc_nxt = pc;
                    pc_nxt       = pc + 16'd1;
                    if (two_word) begin
                        has_operand_nxt = 1'b1;
                        state_nxt       = S_FETCH_ARG;
                    end else begin
                        operand_nxt     = 16'd0;
                        has_operand_nxt = 1'b0;
                        state_nxt       = S_ISSUE;
                    end
                end
            end

            S_FETCH_ARG: begin
                if (!pc_ok) begin
                    fault_nxt  = 1'b1;
                    halted_nxt = 1'b1;
                    state_nxt  = S_HALT;
                end else begin
                    operand_nxt = imem_data;
                    pc_nxt      = pc + 16'd1;
                    state_nxt   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (handshake) begin
                    if (opcode == END_W) begin
                        // END wins over any redirect offered alongside it.
                        halted_nxt = 1'b1;
                        state_nxt  = S_HALT;
                    end else if (jump_en) begin
                        if (!jump_ok) begin
                            fault_nxt  = 1'b1;
                            halted_nxt = 1'b1;
                            state_nxt  = S_HALT;
                        end else begin
                            pc_nxt    = jump_target;
                            state_nxt = S_FETCH_OP;
                        end
                    end else begin
                        state_nxt = S_FETCH_OP;
                    end
                end
            end

            S_HALT: begin
                if (start) begin
                    halted_nxt = 1'b0;
                    fault_nxt  = 1'b0;
                    pc_nxt     = START_W;
                    state_nxt  = S_FETCH_OP;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= START_W;
            opcode      <= 16'd0;
            operand     <= 16'd0;
            has_operand <= 1'b0;
            instr_pc    <= 16'd0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            opcode      <= opcode_nxt;
            operand     <= operand_nxt;
            has_operand <= has_operand_nxt;
            instr_pc    <= instr_pc_nxt;
            halted      <= halted_nxt;
            fault       <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit

module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_read;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] opcode;
    logic [15:0] operand;
    logic        has_operand;
    logic [15:0] instr_pc;
    logic        jump_en;
    logic [15:0] jump_target;
    logic        busy;
    logic        halted;
    logic        fault;

    logic [15:0] mem [0:255];
    int          checks = 0;
    int          errors = 0;
    int          reads  = 0;
    int          bad_reads = 0;
    int          lat;
    int          r0;
    logic [15:0] last_pc;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 16'd256) ? mem[imem_addr[7:0]] : 16'd0;

    instruction_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_read   (imem_read),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .has_operand (has_operand),
        .instr_pc    (instr_pc),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault)
    );

    always @(negedge clk) begin
        if (imem_read) begin
            reads++;
            if (imem_addr >= 16'd100) bad_reads++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits (bounded) for instr_valid; lat = negedges counted since the last posedge event.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 20);
        check("valid_timeout", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic expect_pkt(input logic [15:0] eop, input logic [15:0] earg,
                              input logic ehas, input logic [15:0] epc, input int elat);
        wait_valid(lat);
        if (elat > 0) check("latency", lat, elat);
        check("opcode", opcode, eop);
        check("operand", operand, earg);
        check("has_operand", has_operand, ehas);
        check("instr_pc", instr_pc, epc);
    endtask

    task automatic accept(input logic jen, input logic [15:0] jt);
        instr_ready = 1'b1;
        jump_en     = jen;
        jump_target = jt;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        jump_en     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'd5;
        mem[0]  = 16'd0;  mem[1] = 16'd998;
        mem[2]  = 16'd1;  mem[3] = 16'd999;
        mem[21] = 16'd21; mem[22] = 16'd11;
        mem[35] = 16'd25;

        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_target = 16'd0;
        #12;
        check("reset_outputs",
              {opcode, operand},
              32'd0);
        check("reset_flags",
              {instr_pc, 9'd0, has_operand, instr_valid, imem_read, busy, halted, fault, imem_addr == 16'd0},
              32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_activity", {busy, instr_valid, imem_read}, 3'b000);

        // Two-word, two-word, one-word with latencies 3, 3, 2.
        pulse_start();
        expect_pkt(16'd0, 16'd998, 1'b1, 16'd0, 3);
        check("busy_issue", busy, 1'b1);
        accept(1'b0, 16'd0);
        expect_pkt(16'd1, 16'd999, 1'b1, 16'd2, 3);
        accept(1'b0, 16'd0);
        expect_pkt(16'd5, 16'd0, 1'b0, 16'd4, 2);
        accept(1'b0, 16'd0);

        // Backpressure on the packet at address 5.
        expect_pkt(16'd5, 16'd0, 1'b0, 16'd5, 2);
        r0 = reads;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold", {instr_valid, imem_read, instr_pc}, {1'b1, 1'b0, 16'd5});
            check("bp_pc", imem_addr, 16'd6);
        end
        check("bp_no_fetch", reads - r0, 0);
        accept(1'b0, 16'd0);
        expect_pkt(16'd5, 16'd0, 1'b0, 16'd6, 2);
        check("one_fetch_after_bp", reads - r0, 1);
        accept(1'b0, 16'd0);

        for (int a = 7; a <= 20; a++) begin
            expect_pkt(16'd5, 16'd0, 1'b0, 16'(a), 2);
            accept(1'b0, 16'd0);
        end

        // JNPZ taken to 11, then not taken falling through to 23.
        expect_pkt(16'd21, 16'd11, 1'b1, 16'd21, 3);
        accept(1'b1, 16'd11);
        for (int a = 11; a <= 20; a++) begin
            expect_pkt(16'd5, 16'd0, 1'b0, 16'(a), 2);
            accept(1'b0, 16'd0);
        end
        expect_pkt(16'd21, 16'd11, 1'b1, 16'd21, 3);
        accept(1'b0, 16'd11);
        for (int a = 23; a <= 34; a++) begin
            expect_pkt(16'd5, 16'd0, 1'b0, 16'(a), 2);
            accept(1'b0, 16'd0);
        end

        // END with a simultaneous jump request: jump ignored, halt.
        expect_pkt(16'd25, 16'd0, 1'b0, 16'd35, 2);
        accept(1'b1, 16'd3);
        check("end_halt", {halted, busy, instr_valid, fault}, 4'b1000);
        instr_ready = 1'b1; jump_en = 1'b1; jump_target = 16'd7;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("halt_stable", {halted, busy, instr_valid, imem_read}, 4'b1000);
            check("halt_pc", imem_addr, 16'd36);
        end
        instr_ready = 1'b0; jump_en = 1'b0;

        // Restart, then jump out of range.
        pulse_start();
        expect_pkt(16'd0, 16'd998, 1'b1, 16'd0, 3);
        check("restart_clears_halt", halted, 1'b0);
        accept(1'b1, 16'd120);
        check("jump_fault", {fault, halted, busy, instr_valid}, 4'b1100);

        // Program without END runs off the end of memory.
        mem[35] = 16'd5;
        pulse_start();
        check("restart_clears_fault", fault, 1'b0);
        instr_ready = 1'b1;
        last_pc = 16'hFFFF;
        for (int k = 0; k < 400 && !halted; k++) begin
            @(negedge clk);
            if (instr_valid) last_pc = instr_pc;
        end
        instr_ready = 1'b0;
        check("runoff_fault", {fault, halted}, 2'b11);
        check("runoff_last_pc", last_pc, 16'd99);
        check("no_read_past_depth", bad_reads, 0);

        // Asynchronous reset in FETCH_ARG.
        pulse_start();
        @(posedge clk);
        #1;
        check("in_fetch_arg", {busy, imem_read, instr_valid, imem_addr}, {3'b110, 16'd1});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_flags",
              {has_operand, instr_valid, imem_read, busy, halted, fault}, 6'd0);
        check("async_reset_words", {opcode, instr_pc}, 32'd0);
        check("async_reset_operand", {operand, imem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_reset_idle", {busy, instr_valid, imem_read}, 3'b000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
